fluxo_dados_jogo: RTL and testbench

Datapath responder to the game control unit. It consumes the unit's control strobes (rst_global, zera_CS, e_seed_reg, zera_CJ, inc_jogador) and returns its status inputs: a clean one-cycle `passa` pulse from the raw button, and `CJ_fim`. It also holds the free-running seed counter (CS), the captured seed, the current-player counter (CJ), and the derived werewolf index.

---
 rtl/fluxo_dados_jogo.sv | 194 +++++++++++++++++++
 tb/tb_fluxo_dados_jogo.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fluxo_dados_jogo.sv
// fluxo_dados_jogo: datapath for the game control unit.
// Button conditioning, seed counter/register, werewolf modulo, player counter.
module fluxo_dados_jogo #(
    parameter int N_JOGADORES = 6,
    parameter int SEED_W      = 8,
    parameter int DEB_CICLOS  = 4,
    localparam int JW = $clog2(N_JOGADORES),
    localparam int DW = $clog2(DEB_CICLOS + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          botao_passa,
    input  logic          rst_global,
    input  logic          zera_CS,
    input  logic          e_seed_reg,
    input  logic          zera_CJ,
    input  logic          inc_jogador,
    output logic          passa,
    output logic          CJ_fim,
    output logic [JW-1:0] jogador_atual,
    output logic [SEED_W-1:0] seed,
    output logic [JW-1:0] lobo_idx,
    output logic          papeis_ok,
    output logic          eh_lobo,
    output logic [1:0]    db_estado_mod
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CALCULA = 2'd1,
        PRONTO  = 2'd2
    } estado_t;

    localparam logic [SEED_W-1:0] N_S = SEED_W'(N_JOGADORES);
    localparam logic [JW-1:0] ULTIMO = JW'(N_JOGADORES - 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CICLOS - 1);

    logic          sinc1;
    logic          sinc2;
    logic [DW-1:0] deb_cnt;
    logic          deb_nivel;
    logic          deb_ant;

    logic [SEED_W-1:0] cs;
    logic [SEED_W-1:0] seed_r;
    logic [SEED_W-1:0] seed_novo;
    logic [SEED_W-1:0] resto;
    logic [JW-1:0]     lobo_r;
    logic              ok_r;
    logic [JW-1:0]     cj;

    estado_t estado;
    estado_t prox;

    // 2-FF synchronizer for the raw button
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sinc1 <= 1'b0;
            sinc2 <= 1'b0;
        end else if (rst_global) begin
            sinc1 <= 1'b0;
            sinc2 <= 1'b0;
        end else begin
            sinc1 <= botao_passa;
            sinc2 <= sinc1;
        end
    end

    // Debounce: accept a new level after DEB_CICLOS equal samples
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            deb_cnt   <= '0;
            deb_nivel <= 1'b0;
        end else if (rst_global) begin
            deb_cnt   <= '0;
            deb_nivel <= 1'b0;
        end else if (sinc2 != deb_nivel) begin
            if (deb_cnt == DEB_MAX) begin
                deb_cnt   <= '0;
                deb_nivel <= sinc2;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end else begin
            deb_cnt <= '0;
        end
    end

    // Registered rising-edge pulse of the debounced level
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            deb_ant <= 1'b0;
            passa   <= 1'b0;
        end else if (rst_global) begin
            deb_ant <= 1'b0;
            passa   <= 1'b0;
        end else begin
            deb_ant <= deb_nivel;
            passa   <= deb_nivel & ~deb_ant;
        end
    end

    // Free-running seed counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cs <= '0;
        end else if (rst_global || zera_CS) begin
            cs <= '0;
        end else begin
            cs <= cs + SEED_W'(1);
        end
    end

    // A zero seed is never stored: it becomes 1
    assign seed_novo = (cs == '0) ? SEED_W'(1) : cs;

    // Seed register capture
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            seed_r <= '0;
        end else if (rst_global) begin
            seed_r <= '0;
        end else if (e_seed_reg) begin
            seed_r <= seed_novo;
        end
    end

    // Modulo FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado <= OCIOSO;
        end else if (rst_global) begin
            estado <= OCIOSO;
        end else begin
            estado <= prox;
        end
    end

    // Modulo FSM next state; a capture restarts from any state
    always_comb begin
        prox = estado;
        if (e_seed_reg) begin
            prox = CALCULA;
        end else begin
            unique case (estado)
                CALCULA: if (resto < N_S) prox = PRONTO;
                default: prox = estado;
            endcase
        end
    end

    // Modulo datapath: repeated subtraction, one per cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            resto  <= '0;
            lobo_r <= '0;
            ok_r   <= 1'b0;
        end else if (rst_global) begin
            resto  <= '0;
            lobo_r <= '0;
            ok_r   <= 1'b0;
        end else if (e_seed_reg) begin
            resto <= seed_novo;
            ok_r  <= 1'b0;
        end else if (estado == CALCULA) begin
            if (resto >= N_S) begin
                resto <= resto - N_S;
            end else begin
                lobo_r <= resto[JW-1:0];
                ok_r   <= 1'b1;
            end
        end
    end

    // Player counter, saturating at the last player
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cj <= '0;
        end else if (rst_global || zera_CJ) begin
            cj <= '0;
        end else if (inc_jogador && cj != ULTIMO) begin
            cj <= cj + JW'(1);
        end
    end

    assign jogador_atual = cj;
    assign CJ_fim        = (cj == ULTIMO);
    assign seed          = seed_r;
    assign lobo_idx      = lobo_r;
    assign papeis_ok     = ok_r;
    assign eh_lobo       = ok_r & (cj == lobo_r);
    assign db_estado_mod = estado;

endmodule

// File: tb/tb_fluxo_dados_jogo.sv
// tb_fluxo_dados_jogo: directed self-checking bench for fluxo_dados_jogo.
// N=6, SEED_W=8, DEB_CICLOS=4.
module tb_fluxo_dados_jogo;

    logic       clock;
    logic       reset_n;
    logic       botao_passa;
    logic       rst_global;
    logic       zera_CS;
    logic       e_seed_reg;
    logic       zera_CJ;
    logic       inc_jogador;
    logic       passa;
    logic       CJ_fim;
    logic [2:0] jogador_atual;
    logic [7:0] seed;
    logic [2:0] lobo_idx;
    logic       papeis_ok;
    logic       eh_lobo;
    logic [1:0] db_estado_mod;

    int errors = 0;
    int checks = 0;
    int pulsos;
    int pos;

    fluxo_dados_jogo #(
        .N_JOGADORES(6),
        .SEED_W(8),
        .DEB_CICLOS(4)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .botao_passa(botao_passa),
        .rst_global(rst_global),
        .zera_CS(zera_CS),
        .e_seed_reg(e_seed_reg),
        .zera_CJ(zera_CJ),
        .inc_jogador(inc_jogador),
        .passa(passa),
        .CJ_fim(CJ_fim),
        .jogador_atual(jogador_atual),
        .seed(seed),
        .lobo_idx(lobo_idx),
        .papeis_ok(papeis_ok),
        .eh_lobo(eh_lobo),
        .db_estado_mod(db_estado_mod)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        botao_passa = 1'b0;
        rst_global  = 1'b0;
        zera_CS     = 1'b0;
        e_seed_reg  = 1'b0;
        zera_CJ     = 1'b0;
        inc_jogador = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // 1. reset state, then async reset mid-operation
        check("rst_seed", seed, 0);
        check("rst_ok", papeis_ok, 0);
        check("rst_cj", jogador_atual, 0);
        check("rst_fim", CJ_fim, 0);
        zera_CS = 1'b1;
        tick();
        zera_CS = 1'b0;
        repeat (20) tick();
        e_seed_reg = 1'b1;
        tick();
        e_seed_reg = 1'b0;
        check("pre_seed20", seed, 20);
        check("pre_state", db_estado_mod, 1);
        inc_jogador = 1'b1;
        tick();
        tick();
        inc_jogador = 1'b0;
        check("pre_cj2", jogador_atual, 2);
        #1;
        reset_n = 1'b0;
        #1;
        check("ar_seed", seed, 0);
        check("ar_cj", jogador_atual, 0);
        check("ar_fim", CJ_fim, 0);
        check("ar_lobo", lobo_idx, 0);
        check("ar_ok", papeis_ok, 0);
        check("ar_eh", eh_lobo, 0);
        check("ar_passa", passa, 0);
        check("ar_state", db_estado_mod, 0);
        #1;
        reset_n = 1'b1;
        repeat (10) tick();
        check("ar10_seed", seed, 0);
        check("ar10_ok", papeis_ok, 0);

        // 2. debounce: 3-cycle glitch
        botao_passa = 1'b1;
        repeat (3) tick();
        botao_passa = 1'b0;
        pulsos = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (passa) pulsos++;
        end
        check("glitch_pulses", pulsos, 0);

        // 20-cycle press: one pulse, 7 cycles after press start
        botao_passa = 1'b1;
        pulsos = 0;
        pos = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (passa) begin
                pulsos++;
                pos = i;
            end
        end
        check("press1_pulses", pulsos, 1);
        check("press1_lat", pos, 7);
        botao_passa = 1'b0;
        pulsos = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (passa) pulsos++;
        end
        check("release_pulses", pulsos, 0);
        botao_passa = 1'b1;
        pulsos = 0;
        pos = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (passa) begin
                pulsos++;
                pos = i;
            end
        end
        botao_passa = 1'b0;
        check("press2_pulses", pulsos, 1);
        check("press2_lat", pos, 7);

        // 3. seed 200 -> lobo 2 after 34 cycles
        zera_CS = 1'b1;
        tick();
        zera_CS = 1'b0;
        repeat (200) tick();
        e_seed_reg = 1'b1;
        tick();
        e_seed_reg = 1'b0;
        check("seed200", seed, 200);
        check("calc_ok0", papeis_ok, 0);
        repeat (33) tick();
        check("calc33_ok", papeis_ok, 0);
        check("calc33_state", db_estado_mod, 1);
        tick();
        check("calc34_ok", papeis_ok, 1);
        check("calc34_lobo", lobo_idx, 2);
        check("calc34_state", db_estado_mod, 2);

        // 4. player walk
        zera_CJ = 1'b1;
        tick();
        zera_CJ = 1'b0;
        check("walk_cj0", jogador_atual, 0);
        check("walk_eh0", eh_lobo, 0);
        for (int i = 1; i <= 5; i++) begin
            inc_jogador = 1'b1;
            tick();
            inc_jogador = 1'b0;
            check("walk_cj", jogador_atual, i);
            check("walk_eh", eh_lobo, (i == 2) ? 1 : 0);
            check("walk_fim", CJ_fim, (i == 5) ? 1 : 0);
        end
        inc_jogador = 1'b1;
        tick();
        inc_jogador = 1'b0;
        check("walk_sat", jogador_atual, 5);
        check("walk_sat_fim", CJ_fim, 1);

        // capture with CS=0 -> seed 1, lobo 1
        zera_CS = 1'b1;
        tick();
        zera_CS = 1'b0;
        e_seed_reg = 1'b1;
        tick();
        e_seed_reg = 1'b0;
        check("seed_cs0", seed, 1);
        check("cs0_ok0", papeis_ok, 0);
        tick();
        check("cs0_ok", papeis_ok, 1);
        check("cs0_lobo", lobo_idx, 1);

        // 5. zera_CJ beats inc_jogador
        zera_CJ = 1'b1;
        inc_jogador = 1'b1;
        tick();
        zera_CJ = 1'b0;
        inc_jogador = 1'b0;
        check("zera_vs_inc", jogador_atual, 0);
        check("eh_cj0", eh_lobo, 0);

        // rst_global during CALCULA
        zera_CS = 1'b1;
        tick();
        zera_CS = 1'b0;
        repeat (100) tick();
        e_seed_reg = 1'b1;
        tick();
        e_seed_reg = 1'b0;
        check("seed100", seed, 100);
        inc_jogador = 1'b1;
        tick();
        inc_jogador = 1'b0;
        check("pre_rg_state", db_estado_mod, 1);
        rst_global = 1'b1;
        tick();
        rst_global = 1'b0;
        check("rg_state", db_estado_mod, 0);
        check("rg_ok", papeis_ok, 0);
        check("rg_seed", seed, 0);
        check("rg_cj", jogador_atual, 0);

        // zera_CS with e_seed_reg captures the old CS
        zera_CS = 1'b1;
        tick();
        zera_CS = 1'b0;
        repeat (41) tick();
        zera_CS = 1'b1;
        e_seed_reg = 1'b1;
        tick();
        zera_CS = 1'b0;
        e_seed_reg = 1'b0;
        check("seed_old_cs", seed, 41);
        repeat (7) tick();
        check("s41_ok", papeis_ok, 1);
        check("s41_lobo", lobo_idx, 5);
        repeat (2) tick();
        e_seed_reg = 1'b1;
        tick();
        e_seed_reg = 1'b0;
        check("cs_cleared", seed, 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
